// File: rtl/biriscv_trace_arb.sv
// Dual-slot retire trace arbiter: serialises two retire slots into one trace stream.
// Ports: clk_i/rst_i, slot 0/1 valid+pc+opcode, accept_o, trace valid/pc/opcode/ready,
// overflow_o and retired_o (stats, enabled by macro BIRISCV_TRACE_ARB_STATS_EN).
module biriscv_trace_arb #(
  parameter int DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid0_i,
  input  logic [31:0] pc0_i,
  input  logic [31:0] opcode0_i,
  input  logic        valid1_i,
  input  logic [31:0] pc1_i,
  input  logic [31:0] opcode1_i,
  output logic        accept_o,
  output logic        valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] opcode_o,
  input  logic        ready_i,
  output logic        overflow_o,
  output logic [31:0] retired_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [63:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;

  logic          push0;
  logic          push1;
  logic          pop;
  logic [AW-1:0] wr1_ptr;
  logic [CW-1:0] n_push;

  // Room for a full dual retire, judged on the registered count only.
  assign accept_o = count_q <= CW'(DEPTH - 2);
  assign valid_o  = count_q != '0;

  assign push0 = accept_o & valid0_i;
  assign push1 = accept_o & valid1_i;
  assign pop   = valid_o & ready_i;

  // Slot 1 lands right after slot 0, or at wr_ptr when slot 0 is idle.
  assign wr1_ptr = wr_ptr_q + AW'(push0);
  assign n_push  = CW'(push0) + CW'(push1);

  always_ff @(posedge clk_i) begin
    if (push0)
      mem_q[wr_ptr_q] <= {pc0_i, opcode0_i};
    if (push1)
      mem_q[wr1_ptr] <= {pc1_i, opcode1_i};
  end

  assign {pc_o, opcode_o} = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_q + AW'(n_push);
      rd_ptr_q <= rd_ptr_q + AW'(pop);
      count_q  <= count_q + n_push - CW'(pop);
    end
  end

`ifdef BIRISCV_TRACE_ARB_STATS_EN
  logic        drop;
  logic        overflow_q;
  logic [31:0] retired_q;

  assign drop = (valid0_i | valid1_i) & ~accept_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      overflow_q <= 1'b0;
      retired_q  <= '0;
    end else begin
      if (drop)
        overflow_q <= 1'b1;
      if (pop)
        retired_q <= retired_q + 32'd1;
    end
  end

  assign overflow_o = overflow_q;
  assign retired_o  = retired_q;
`else
  assign overflow_o = 1'b0;
  assign retired_o  = '0;
`endif

endmodule

// File: tb/tb_biriscv_trace_arb.sv
// Self-checking bench for biriscv_trace_arb: directed scenarios plus random
// traffic, compared against a queue-based model of the trace FIFO.
module tb_biriscv_trace_arb;

  localparam int DEPTH = 4;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid0_i;
  logic [31:0] pc0_i;
  logic [31:0] opcode0_i;
  logic        valid1_i;
  logic [31:0] pc1_i;
  logic [31:0] opcode1_i;
  logic        accept_o;
  logic        valid_o;
  logic [31:0] pc_o;
  logic [31:0] opcode_o;
  logic        ready_i;
  logic        overflow_o;
  logic [31:0] retired_o;

  biriscv_trace_arb #(.DEPTH(DEPTH)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .valid0_i  (valid0_i),
    .pc0_i     (pc0_i),
    .opcode0_i (opcode0_i),
    .valid1_i  (valid1_i),
    .pc1_i     (pc1_i),
    .opcode1_i (opcode1_i),
    .accept_o  (accept_o),
    .valid_o   (valid_o),
    .pc_o      (pc_o),
    .opcode_o  (opcode_o),
    .ready_i   (ready_i),
    .overflow_o(overflow_o),
    .retired_o (retired_o)
  );

  always #5 clk_i = ~clk_i;

  logic [63:0] mq[$];
  logic [31:0] m_ret;
  logic        m_ovf;
  int          n_total = 0;
  int          n_pass  = 0;
  int          n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    logic [31:0] e_ret;
    logic        e_ovf;
`ifdef BIRISCV_TRACE_ARB_STATS_EN
    e_ret = m_ret;
    e_ovf = m_ovf;
`else
    e_ret = 32'd0;
    e_ovf = 1'b0;
`endif
    check({tag, ".valid"}, 32'(valid_o), 32'(mq.size() != 0));
    check({tag, ".accept"}, 32'(accept_o), 32'((DEPTH - mq.size()) >= 2));
    if (mq.size() != 0) begin
      check({tag, ".pc"}, pc_o, mq[0][63:32]);
      check({tag, ".op"}, opcode_o, mq[0][31:0]);
    end
    check({tag, ".retired"}, retired_o, e_ret);
    check({tag, ".overflow"}, 32'(overflow_o), 32'(e_ovf));
  endtask

  // One clock: drive inputs, let the edge happen, advance the model, compare.
  task automatic cyc(input string tag,
                     input logic v0, input logic [31:0] p0, input logic [31:0] o0,
                     input logic v1, input logic [31:0] p1, input logic [31:0] o1,
                     input logic rdy);
    bit acc;
    acc       = (DEPTH - mq.size()) >= 2;
    valid0_i  = v0;
    pc0_i     = p0;
    opcode0_i = o0;
    valid1_i  = v1;
    pc1_i     = p1;
    opcode1_i = o1;
    ready_i   = rdy;
    @(posedge clk_i);
    if (mq.size() != 0 && rdy) begin
      void'(mq.pop_front());
      m_ret = m_ret + 32'd1;
    end
    if (acc) begin
      if (v0) mq.push_back({p0, o0});
      if (v1) mq.push_back({p1, o1});
    end else if (v0 | v1) begin
      m_ovf = 1'b1;
    end
    #1;
    check_state(tag);
  endtask

  task automatic idle(input string tag, input logic rdy);
    cyc(tag, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, rdy);
  endtask

  task automatic do_reset(input string tag);
    rst_i    = 1'b1;
    valid0_i = 1'b0;
    valid1_i = 1'b0;
    ready_i  = 1'b0;
    #1;
    check({tag, ".rst_valid"}, 32'(valid_o), 32'd0);
    check({tag, ".rst_accept"}, 32'(accept_o), 32'd1);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    mq.delete();
    m_ret = 32'd0;
    m_ovf = 1'b0;
    check_state({tag, ".post"});
  endtask

  initial begin
    logic [31:0] pc;
    rst_i     = 1'b1;
    valid0_i  = 1'b0;
    valid1_i  = 1'b0;
    pc0_i     = '0;
    pc1_i     = '0;
    opcode0_i = '0;
    opcode1_i = '0;
    ready_i   = 1'b0;
    m_ret     = '0;
    m_ovf     = 1'b0;
    @(posedge clk_i);
    #1;
    do_reset("reset");

    // Dual retire then drain in order.
    cyc("dual", 1'b1, 32'h80000000, 32'h00000013,
        1'b1, 32'h80000004, 32'h00100093, 1'b1);
    check("dual.pc0", pc_o, 32'h80000000);
    idle("dual.d1", 1'b1);
    check("dual.pc1", pc_o, 32'h80000004);
    idle("dual.d2", 1'b1);
    check("dual.empty", 32'(valid_o), 32'd0);

    // Slot 1 alone lands without a gap.
    do_reset("r1");
    cyc("s1", 1'b0, 32'h0, 32'h0, 1'b1, 32'h100, 32'h13, 1'b0);
    check("s1.pc", pc_o, 32'h100);
    idle("s1.pop", 1'b1);
    check("s1.empty", 32'(valid_o), 32'd0);

    // Fill to DEPTH, then a dropped third dual retire.
    do_reset("r2");
    cyc("f1", 1'b1, 32'h10, 32'h1, 1'b1, 32'h14, 32'h2, 1'b0);
    cyc("f2", 1'b1, 32'h18, 32'h3, 1'b1, 32'h1c, 32'h4, 1'b0);
    check("full.accept", 32'(accept_o), 32'd0);
    cyc("f3", 1'b1, 32'h20, 32'h5, 1'b1, 32'h24, 32'h6, 1'b0);
    for (int i = 0; i < 5; i++) idle("drain", 1'b1);

    // Push and pop together at count=2.
    do_reset("r3");
    cyc("c2", 1'b1, 32'h200, 32'h7, 1'b1, 32'h204, 32'h8, 1'b0);
    cyc("c3", 1'b1, 32'h208, 32'h9, 1'b1, 32'h20c, 32'ha, 1'b1);
    check("c3.size", 32'(mq.size()), 32'd3);
    check("c3.pc", pc_o, 32'h204);
    for (int i = 0; i < 4; i++) idle("c3.drain", 1'b1);

    // Continuous dual retire with ready toggling.
    do_reset("r4");
    pc = 32'h1000;
    for (int i = 0; i < 20; i++) begin
      cyc("burst", 1'b1, pc, pc ^ 32'hffff, 1'b1, pc + 4, pc ^ 32'haaaa,
          1'(i % 2 == 0));
      pc = pc + 8;
    end
    for (int i = 0; i < 6; i++) idle("burst.drain", 1'b1);

    // Mid-operation reset with 3 entries queued.
    cyc("q1", 1'b1, 32'h300, 32'h1, 1'b1, 32'h304, 32'h2, 1'b0);
    cyc("q2", 1'b1, 32'h308, 32'h3, 1'b0, 32'h0, 32'h0, 1'b0);
    check("q.size", 32'(mq.size()), 32'd3);
    do_reset("r5");
    idle("r5.idle", 1'b1);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      cyc("rand", 1'($urandom), $urandom, $urandom,
          1'($urandom), $urandom, $urandom, 1'($urandom_range(0, 3) != 0));
    end
    for (int i = 0; i < 6; i++) idle("rand.drain", 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
